fwd_hazard_ctrl: RTL and testbench
==================================

# fwd_hazard_ctrl

Forwarding and hazard controller for the 8-bit pipelined core (IF/ID/EX/MEM/WB). It tracks the destination registers of in-flight instructions and issues the registered 2-bit select codes that steer both EX-stage operand forwarding muxes. It also detects load-use hazards, raises a one-cycle stall with an EX bubble, and honours branch flushes. It owns no datapath; it only sequences the muxes and pipeline enables.

## Interface
- REG_AW, 3: register address width (8 architectural registers; r0 hard-wired zero).
- CNT_W, 16: width of the saturating stall counter.

- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_valid  in  1  ID stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  source registers of the ID instruction.
- id_rd  in  REG_AW  destination register of the ID instruction.
- id_we  in  1  ID instruction writes id_rd.
- id_load  in  1  ID instruction is a load (data available at end of MEM).
- flush  in  1  branch taken in EX; kill the ID instruction.
- stall  out  1  combinational; hold PC and IF/ID register this cycle.
- ex_bubble  out  1  registered; EX stage holds a NOP this cycle.
- fwd_sel1, fwd_sel2  out  2  registered operand-mux selects for the instruction in EX.
- stall_cnt  out  CNT_W  registered count of stall cycles, saturating.

## Operation
- Select encoding (shared with the operand muxes): 2'b00 register-file data; 2'b01 forward from EX/MEM result; 2'b11 forward from MEM/WB result; 2'b10 never driven. Forward-value source mux uses bit 1.
- Tracker: three entries EX, MEM, WB, each {v, rd, we, load}. Entry "writes" when v & we & rd != 0.
- Each rising edge: WB <= MEM; MEM <= EX; EX <= ID info, unless the ID slot is killed (see below), in which case EX <= invalid.
- Hazard for source rsN of the ID instruction (only when id_valid and rsN != 0):
  - EX entry writes rsN and EX.load: load-use, stall = 1.
  - else EX entry writes rsN: next fwd_selN = 2'b01.
  - else MEM entry writes rsN: next fwd_selN = 2'b11.
  - else next fwd_selN = 2'b00.
- EX match has priority over MEM match (newest producer wins).
- stall = load-use on rs1 or rs2, and not flush.
- ID slot killed when stall = 1 or flush = 1 or id_valid = 0: EX entry cleared, ex_bubble <= 1, fwd_sel1/2 <= 2'b00.
- Otherwise ex_bubble <= 0 and fwd_sel1/2 take the computed values.
- Flush overrides stall: with flush = 1, stall = 0 and the ID instruction is discarded; MEM/WB shift normally.
- stall_cnt increments on every cycle with stall = 1; holds at all-ones.

## Timing
- Reset (async, any time): EX/MEM/WB entries invalid, fwd_sel1/2 = 2'b00, ex_bubble = 1, stall_cnt = 0; stall therefore 0. Reset mid-stall drops the stall immediately.
- Forward decision latency: computed in the ID cycle, valid on fwd_sel outputs for exactly the following cycle (instruction in EX).
- Load-use: exactly one stall cycle. Next cycle the load is in MEM, the bubble in EX, the held ID instruction resolves to 2'b11 for that operand.
- Back-to-back producers of the same rd: consumer gets 2'b01 (most recent).
- rs1 == rs2: both selects equal.
- r0 as source or destination never forwards or stalls.
- WB entry used only for retirement ordering; same-cycle register-file write/read bypass is handled by the register file, not this block.

## Test plan
- Reset: assert rst_n = 0 mid-run -> fwd_sel1/2 = 00, ex_bubble = 1, stall = 0, stall_cnt = 0 asynchronously.
- ALU chain: add r1 then sub r2,r1,r3 -> cycle after sub in ID, fwd_sel1 = 01, fwd_sel2 = 00, no stall; add r4,r1,r1 one instruction later -> fwd_sel1 = fwd_sel2 = 11.
- Load-use: lw r5 then add r6,r5,r2 -> stall = 1 for one cycle, ex_bubble = 1, then fwd_sel1 = 11, stall_cnt = 1.
- Priority: add r1; add r1; sub r2,r1,r1 -> fwd_sel1 = fwd_sel2 = 01.
- Flush vs stall: lw r5 in EX, dependent add in ID with flush = 1 -> stall = 0, ex_bubble = 1, fwd_sel = 00, stall_cnt unchanged.
- r0 and saturation: add r0 then use r0 -> selects 00; force 2^CNT_W + 5 load-use stalls -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/fwd_hazard_if.sv
// Pipeline-control bundle between the ID-stage decode and the forwarding/hazard controller.
interface fwd_hazard_if #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_we;
  logic              id_load;
  logic              flush;
  logic              stall;
  logic              ex_bubble;
  logic [1:0]        fwd_sel1;
  logic [1:0]        fwd_sel2;
  logic [CNT_W-1:0]  stall_cnt;

  modport master (
    output id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, flush,
    input  stall, ex_bubble, fwd_sel1, fwd_sel2, stall_cnt
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_rd, id_we, id_load, flush,
    output stall, ex_bubble, fwd_sel1, fwd_sel2, stall_cnt
  );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard controller: tracks EX/MEM/WB destinations and
// registers the EX operand-mux selects, stall, bubble and a saturating stall count.
module fwd_hazard_ctrl #(
  parameter int unsigned REG_AW = 3,
  parameter int unsigned CNT_W  = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  fwd_hazard_if.slave  bus
);

  localparam logic [1:0] SEL_RF  = 2'b00;
  localparam logic [1:0] SEL_EXM = 2'b01;
  localparam logic [1:0] SEL_MWB = 2'b11;

  typedef struct packed {
    logic              v;
    logic [REG_AW-1:0] rd;
    logic              we;
    logic              load;
  } ent_t;

  ent_t             ex_q, mem_q, wb_q;
  ent_t             ex_d, id_ent;
  logic [1:0]       sel1_q, sel2_q, sel1_d, sel2_d;
  logic             bubble_q, bubble_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lu1, lu2, stall_c, kill;

  // r0 is never a real producer, so a zero rd can never match
  function automatic logic writes(input ent_t e, input logic [REG_AW-1:0] rs);
    return e.v && e.we && (e.rd != '0) && (e.rd == rs);
  endfunction

  // Newest producer wins: EX/MEM result before MEM/WB result
  function automatic logic [1:0] sel_for(input ent_t ex, input ent_t mem,
                                         input logic [REG_AW-1:0] rs);
    if (writes(ex, rs))       return SEL_EXM;
    else if (writes(mem, rs)) return SEL_MWB;
    else                      return SEL_RF;
  endfunction

  always_comb begin
    id_ent      = '0;
    id_ent.v    = bus.id_valid;
    id_ent.rd   = bus.id_rd;
    id_ent.we   = bus.id_we;
    id_ent.load = bus.id_load;

    lu1     = bus.id_valid && ex_q.load && writes(ex_q, bus.id_rs1);
    lu2     = bus.id_valid && ex_q.load && writes(ex_q, bus.id_rs2);
    stall_c = (lu1 || lu2) && !bus.flush;
    kill    = stall_c || bus.flush || !bus.id_valid;

    ex_d     = id_ent;
    sel1_d   = sel_for(ex_q, mem_q, bus.id_rs1);
    sel2_d   = sel_for(ex_q, mem_q, bus.id_rs2);
    bubble_d = kill;
    if (kill) begin
      ex_d   = '0;
      sel1_d = SEL_RF;
      sel2_d = SEL_RF;
    end

    cnt_d = cnt_q;
    if (stall_c && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q     <= '0;
      mem_q    <= '0;
      wb_q     <= '0;
      sel1_q   <= SEL_RF;
      sel2_q   <= SEL_RF;
      bubble_q <= 1'b1;
      cnt_q    <= '0;
    end else begin
      wb_q     <= mem_q;
      mem_q    <= ex_q;
      ex_q     <= ex_d;
      sel1_q   <= sel1_d;
      sel2_q   <= sel2_d;
      bubble_q <= bubble_d;
      cnt_q    <= cnt_d;
    end
  end

  // WB only records retirement order; it must always be last cycle's MEM
  wb_follows_mem: assert property (@(posedge clk) disable iff (!rst_n) wb_q == $past(mem_q));

  assign bus.stall     = stall_c;
  assign bus.ex_bubble = bubble_q;
  assign bus.fwd_sel1  = sel1_q;
  assign bus.fwd_sel2  = sel2_q;
  assign bus.stall_cnt = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl; a narrow-counter instance covers saturation.
module tb_fwd_hazard_ctrl;
  localparam int unsigned REG_AW  = 3;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CNT_WS  = 6;
  localparam int unsigned N_SAT   = (1 << CNT_WS) + 5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  fwd_hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_W))  bus  ();
  fwd_hazard_if #(.REG_AW(REG_AW), .CNT_W(CNT_WS)) bus_s ();

  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
  fwd_hazard_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_WS)) dut_s (.clk(clk), .rst_n(rst_n), .bus(bus_s));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic [2:0] rd, input logic we, input logic ld, input logic fl);
    bus.id_valid   = v;   bus_s.id_valid = v;
    bus.id_rs1     = rs1; bus_s.id_rs1   = rs1;
    bus.id_rs2     = rs2; bus_s.id_rs2   = rs2;
    bus.id_rd      = rd;  bus_s.id_rd    = rd;
    bus.id_we      = we;  bus_s.id_we    = we;
    bus.id_load    = ld;  bus_s.id_load  = ld;
    bus.flush      = fl;  bus_s.flush    = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    issue(0, 0, 0, 0, 0, 0, 0);
    #11;
    check("rst_sel1",   32'(bus.fwd_sel1), 32'h0);
    check("rst_sel2",   32'(bus.fwd_sel2), 32'h0);
    check("rst_bubble", 32'(bus.ex_bubble), 32'h1);
    check("rst_stall",  32'(bus.stall), 32'h0);
    check("rst_cnt",    32'(bus.stall_cnt), 32'h0);
    rst_n = 1'b1;
    tick();

    // ALU chain: add r1,r2,r3 ; sub r2,r1,r3 ; add r4,r1,r1
    issue(1, 2, 3, 1, 1, 0, 0); tick();
    check("add_bubble", 32'(bus.ex_bubble), 32'h0);
    check("add_sel1",   32'(bus.fwd_sel1), 32'h0);
    issue(1, 1, 3, 2, 1, 0, 0);
    check("sub_stall", 32'(bus.stall), 32'h0);
    tick();
    check("sub_sel1", 32'(bus.fwd_sel1), 32'h1);
    check("sub_sel2", 32'(bus.fwd_sel2), 32'h0);
    issue(1, 1, 1, 4, 1, 0, 0); tick();
    check("mem_sel1", 32'(bus.fwd_sel1), 32'h3);
    check("mem_sel2", 32'(bus.fwd_sel2), 32'h3);

    // Load-use: lw r5 ; add r6,r5,r2
    issue(1, 0, 0, 5, 1, 1, 0); tick();
    issue(1, 5, 2, 6, 1, 0, 0);
    check("lu_stall", 32'(bus.stall), 32'h1);
    tick();
    check("lu_bubble", 32'(bus.ex_bubble), 32'h1);
    check("lu_sel1b",  32'(bus.fwd_sel1), 32'h0);
    check("lu_cnt",    32'(bus.stall_cnt), 32'h1);
    check("lu_stall2", 32'(bus.stall), 32'h0);
    tick();
    check("lu_bubble2", 32'(bus.ex_bubble), 32'h0);
    check("lu_sel1",    32'(bus.fwd_sel1), 32'h3);
    check("lu_sel2",    32'(bus.fwd_sel2), 32'h0);
    check("lu_cnt2",    32'(bus.stall_cnt), 32'h1);

    // Priority: add r1 ; add r1 ; sub r2,r1,r1
    issue(1, 0, 0, 1, 1, 0, 0); tick();
    issue(1, 0, 0, 1, 1, 0, 0); tick();
    issue(1, 1, 1, 2, 1, 0, 0); tick();
    check("prio_sel1", 32'(bus.fwd_sel1), 32'h1);
    check("prio_sel2", 32'(bus.fwd_sel2), 32'h1);

    // Flush beats stall: lw r5 ; add r6,r5,r5 flushed ; add r7,r5,r0
    issue(1, 0, 0, 5, 1, 1, 0); tick();
    issue(1, 5, 5, 6, 1, 0, 1);
    check("fl_stall", 32'(bus.stall), 32'h0);
    tick();
    check("fl_bubble", 32'(bus.ex_bubble), 32'h1);
    check("fl_sel1",   32'(bus.fwd_sel1), 32'h0);
    check("fl_sel2",   32'(bus.fwd_sel2), 32'h0);
    check("fl_cnt",    32'(bus.stall_cnt), 32'h1);
    issue(1, 5, 0, 7, 1, 0, 0);
    check("fl_next_stall", 32'(bus.stall), 32'h0);
    tick();
    check("fl_next_sel1", 32'(bus.fwd_sel1), 32'h3);
    check("fl_next_bub",  32'(bus.ex_bubble), 32'h0);

    // r0: add r0 ; lw r0 ; add r3,r0,r0
    issue(1, 1, 2, 0, 1, 0, 0); tick();
    issue(1, 0, 0, 0, 1, 1, 0); tick();
    issue(1, 0, 0, 3, 1, 0, 0);
    check("r0_stall", 32'(bus.stall), 32'h0);
    tick();
    check("r0_sel1",   32'(bus.fwd_sel1), 32'h0);
    check("r0_sel2",   32'(bus.fwd_sel2), 32'h0);
    check("r0_bubble", 32'(bus.ex_bubble), 32'h0);

    issue(0, 3, 3, 3, 1, 0, 0); tick();
    check("idle_bubble", 32'(bus.ex_bubble), 32'h1);

    // Reset asserted while a load-use stall is showing
    issue(1, 0, 0, 5, 1, 1, 0); tick();
    issue(1, 5, 0, 6, 1, 0, 0);
    check("mid_stall", 32'(bus.stall), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_stall",  32'(bus.stall), 32'h0);
    check("mid_rst_bubble", 32'(bus.ex_bubble), 32'h1);
    check("mid_rst_sel1",   32'(bus.fwd_sel1), 32'h0);
    check("mid_rst_cnt",    32'(bus.stall_cnt), 32'h0);
    issue(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // Saturation: self-dependent load stalls every other cycle
    issue(1, 5, 0, 5, 1, 1, 0);
    for (int i = 0; i < int'(2 * N_SAT); i++) tick();
    check("sat_cnt_narrow", 32'(bus_s.stall_cnt), 32'h3F);
    check("sat_cnt_wide",   32'(bus.stall_cnt), 32'(N_SAT));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
